// File: rtl/pio_seq_pkg.sv
// Shared encodings for the PIO write sequencer: op codes, PIO register offsets
// and the sequencer state type.
package pio_seq_pkg;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLR   = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    localparam logic [2:0] OFS_DATA = 3'd0;
    localparam logic [2:0] OFS_SET  = 3'd4;
    localparam logic [2:0] OFS_CLR  = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_e;

    function automatic logic [2:0] op_to_ofs(input logic [1:0] op);
        logic [2:0] ofs;
        case (op)
            OP_SET:  ofs = OFS_SET;
            OP_CLR:  ofs = OFS_CLR;
            default: ofs = OFS_DATA;
        endcase
        return ofs;
    endfunction

endpackage

// File: rtl/pio_write_sequencer_rr_arbiter.sv
// Round-robin arbiter: combinational pick starting at a registered priority
// index, which moves to just past the winner when advance is pulsed.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    input  logic [IDX_W-1:0]   adv_idx,
    output logic               pick_valid,
    output logic [IDX_W-1:0]   pick_idx,
    output logic [NUM_REQ-1:0] pick_onehot
);

    logic [IDX_W-1:0] prio_q;
    logic [IDX_W-1:0] prio_d;
    logic [IDX_W-1:0] cand;

    // prio_q holds the index with top priority, so reset value 0 favours requester 0.
    always_comb begin
        pick_valid  = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(prio_q) + i) % NUM_REQ);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
        pick_onehot[pick_idx] = pick_valid;
    end

    always_comb begin
        prio_d = prio_q;
        if (advance) begin
            prio_d = (adv_idx == IDX_W'(NUM_REQ - 1)) ? '0 : adv_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_q <= '0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/pio_write_sequencer.sv
// Avalon-MM master sharing one output PIO between NUM_REQ requesters with
// round-robin arbitration. Define PIO_SEQ_SHADOW_EN to add the shadow_q output.
module pio_write_sequencer
    import pio_seq_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_W     = 7,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [2*NUM_REQ-1:0]      req_op,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic [2:0]                m_address,
    output logic                      m_chipselect,
    output logic                      m_write_n,
    output logic [31:0]               m_writedata
`ifdef PIO_SEQ_SHADOW_EN
    ,
    output logic [DATA_W-1:0]         shadow_q
`endif
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
            $error("pio_write_sequencer: NUM_REQ must be in 2..8");
        end
        if (GAP_CYCLES > 255) begin : g_bad_gap
            $error("pio_write_sequencer: GAP_CYCLES must be in 0..255");
        end
        if (DATA_W < 1 || DATA_W > 32) begin : g_bad_data_w
            $error("pio_write_sequencer: DATA_W must be in 1..32");
        end
    endgenerate

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     winner_q, winner_d;
    logic [NUM_REQ-1:0]   onehot_q, onehot_d;
    logic [1:0]           op_q, op_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [7:0]           gap_cnt_q, gap_cnt_d;

    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic                 issue;
    logic                 bus_en;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .advance     (issue),
        .adv_idx     (winner_q),
        .pick_valid  (pick_valid),
        .pick_idx    (pick_idx),
        .pick_onehot (pick_onehot)
    );

    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        onehot_d  = onehot_q;
        op_d      = op_q;
        data_d    = data_q;
        gap_cnt_d = gap_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    winner_d = pick_idx;
                    onehot_d = pick_onehot;
                    op_d     = req_op[2*int'(pick_idx) +: 2];
                    data_d   = req_data[int'(pick_idx)*DATA_W +: DATA_W];
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                gap_cnt_d = '0;
                state_d   = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            winner_q  <= '0;
            onehot_q  <= '0;
            op_q      <= OP_NOP;
            data_q    <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            onehot_q  <= onehot_d;
            op_q      <= op_d;
            data_q    <= data_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Bus outputs decode straight from state so reset idles them without a clock edge.
    always_comb begin
        issue        = (state_q == ISSUE);
        bus_en       = issue && (op_q != OP_NOP);
        grant        = issue ? onehot_q : '0;
        busy         = (state_q != IDLE);
        m_chipselect = bus_en;
        m_write_n    = ~bus_en;
        m_address    = bus_en ? op_to_ofs(op_q) : OFS_DATA;
        m_writedata  = bus_en ? 32'(data_q) : '0;
    end

`ifdef PIO_SEQ_SHADOW_EN
    logic [DATA_W-1:0] shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        if (issue) begin
            case (op_q)
                OP_WRITE: shadow_d = data_q;
                OP_SET:   shadow_d = shadow_q | data_q;
                OP_CLR:   shadow_d = shadow_q & ~data_q;
                default:  shadow_d = shadow_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`endif

endmodule

// File: tb/tb_pio_write_sequencer.sv
// Self-checking bench for pio_write_sequencer: a GAP_CYCLES=0 and a GAP_CYCLES=3
// instance run directed and random traffic against a per-cycle reference model.
module tb_pio_write_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [3:0]  req_a  [2];
    logic [7:0]  op_a   [2];
    logic [27:0] data_a [2];
    logic [3:0]  grant_a[2];
    logic        busy_a [2];
    logic [2:0]  addr_a [2];
    logic        cs_a   [2];
    logic        wn_a   [2];
    logic [31:0] wd_a   [2];
`ifdef PIO_SEQ_SHADOW_EN
    logic [6:0]  sh_a   [2];
`endif

    pio_write_sequencer #(.NUM_REQ(4), .DATA_W(7), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .req(req_a[0]), .req_op(op_a[0]), .req_data(data_a[0]),
        .grant(grant_a[0]), .busy(busy_a[0]), .m_address(addr_a[0]),
        .m_chipselect(cs_a[0]), .m_write_n(wn_a[0]), .m_writedata(wd_a[0])
`ifdef PIO_SEQ_SHADOW_EN
        , .shadow_q(sh_a[0])
`endif
    );

    pio_write_sequencer #(.NUM_REQ(4), .DATA_W(7), .GAP_CYCLES(3)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .req(req_a[1]), .req_op(op_a[1]), .req_data(data_a[1]),
        .grant(grant_a[1]), .busy(busy_a[1]), .m_address(addr_a[1]),
        .m_chipselect(cs_a[1]), .m_write_n(wn_a[1]), .m_writedata(wd_a[1])
`ifdef PIO_SEQ_SHADOW_EN
        , .shadow_q(sh_a[1])
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: one pending write per instance, a cool-down counter and a priority index.
    int          gap_of [2] = '{0, 3};
    int          m_prio [2];
    int          m_cool [2];
    bit          m_v    [2];
    int          m_w    [2];
    logic [1:0]  m_op   [2];
    logic [6:0]  m_data [2];
    logic [6:0]  m_sh   [2];
    bit          pend   [2][4];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_prio[k] = 0; m_cool[k] = 0; m_v[k] = 1'b0; m_w[k] = 0;
            m_op[k] = 2'b11; m_data[k] = '0; m_sh[k] = '0;
            for (int i = 0; i < 4; i++) pend[k][i] = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        bit found;
        int idx;
        if (m_v[k]) begin
            case (m_op[k])
                2'b00:   m_sh[k] = m_data[k];
                2'b01:   m_sh[k] = m_sh[k] | m_data[k];
                2'b10:   m_sh[k] = m_sh[k] & ~m_data[k];
                default: ;
            endcase
            m_prio[k] = (m_w[k] + 1) % 4;
            m_cool[k] = gap_of[k];
            m_v[k]    = 1'b0;
        end else if (m_cool[k] > 0) begin
            m_cool[k]--;
        end else begin
            found = 1'b0;
            for (int j = 0; j < 4; j++) begin
                idx = (m_prio[k] + j) % 4;
                if (!found && req_a[k][idx]) begin
                    found     = 1'b1;
                    m_v[k]    = 1'b1;
                    m_w[k]    = idx;
                    m_op[k]   = op_a[k][idx*2 +: 2];
                    m_data[k] = data_a[k][idx*7 +: 7];
                end
            end
        end
    endtask

    task automatic check_outputs(input int k);
        bit         e_cs;
        logic [2:0] e_addr;
        e_cs   = m_v[k] && (m_op[k] != 2'b11);
        e_addr = !e_cs ? 3'd0 : (m_op[k] == 2'b00) ? 3'd0 : (m_op[k] == 2'b01) ? 3'd4 : 3'd5;
        check($sformatf("grant[%0d]", k), 32'(grant_a[k]), m_v[k] ? (32'd1 << m_w[k]) : 32'd0);
        check($sformatf("chipselect[%0d]", k), 32'(cs_a[k]), 32'(e_cs));
        check($sformatf("write_n[%0d]", k), 32'(wn_a[k]), 32'(!e_cs));
        check($sformatf("address[%0d]", k), 32'(addr_a[k]), 32'(e_addr));
        check($sformatf("writedata[%0d]", k), wd_a[k], e_cs ? 32'(m_data[k]) : 32'd0);
        check($sformatf("busy[%0d]", k), 32'(busy_a[k]), 32'(m_v[k] || m_cool[k] > 0));
`ifdef PIO_SEQ_SHADOW_EN
        check($sformatf("shadow[%0d]", k), 32'(sh_a[k]), 32'(m_sh[k]));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        cyc++;
        @(negedge clk);
        check_outputs(0);
        check_outputs(1);
    endtask

    task automatic set_lane(input int k, input int i, input logic r, input logic [1:0] op,
                            input logic [6:0] d);
        req_a[k][i]        = r;
        op_a[k][i*2 +: 2]  = op;
        data_a[k][i*7 +: 7] = d;
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 2; k++) begin
            req_a[k] = '0; op_a[k] = '0; data_a[k] = '0;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        check_outputs(0);
        check_outputs(1);
    endtask

    task automatic random_stim(input int k);
        for (int i = 0; i < 4; i++) begin
            if (pend[k][i] && m_v[k] && m_w[k] == i) begin
                if ($urandom_range(1, 0) == 0) begin
                    pend[k][i] = 1'b0;
                    set_lane(k, i, 1'b0, 2'($urandom), 7'($urandom));
                end else begin
                    set_lane(k, i, 1'b1, 2'($urandom), 7'($urandom));
                end
            end else if (pend[k][i]) begin
                if ($urandom_range(15, 0) == 0) begin
                    pend[k][i] = 1'b0;
                    req_a[k][i] = 1'b0;
                end
            end else if ($urandom_range(2, 0) == 0) begin
                pend[k][i] = 1'b1;
                set_lane(k, i, 1'b1, 2'($urandom), 7'($urandom));
            end else begin
                set_lane(k, i, 1'b0, 2'($urandom), 7'($urandom));
            end
        end
    endtask

    int g_idx[$];
    int g_cyc[$];

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check("reset grant", 32'(grant_a[0]), 32'd0);
        check("reset write_n", 32'(wn_a[0]), 32'd1);
        check("reset chipselect", 32'(cs_a[0]), 32'd0);
        check("reset busy", 32'(busy_a[0]), 32'd0);
        check("reset writedata", wd_a[0], 32'd0);
        check_outputs(0);
        check_outputs(1);

        // Single full write from requester 0.
        set_lane(0, 0, 1'b1, 2'b00, 7'h55);
        tick();
        check("t1 address", 32'(addr_a[0]), 32'd0);
        check("t1 chipselect", 32'(cs_a[0]), 32'd1);
        check("t1 write_n", 32'(wn_a[0]), 32'd0);
        check("t1 writedata", wd_a[0], 32'h55);
        check("t1 grant", 32'(grant_a[0]), 32'b0001);
        set_lane(0, 0, 1'b0, 2'b00, 7'h00);
        tick();

        // All four held: rotation 0,1,2,3,0 every two cycles.
        do_reset();
        for (int i = 0; i < 4; i++) set_lane(0, i, 1'b1, 2'b00, 7'(i * 9 + 1));
        for (int t = 0; t < 10; t++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                if (grant_a[0][i]) begin
                    g_idx.push_back(i);
                    g_cyc.push_back(cyc);
                end
            end
        end
        check("rr grant count", 32'(g_idx.size()), 32'd5);
        for (int i = 0; i < g_idx.size() && i < 5; i++) begin
            check($sformatf("rr order %0d", i), 32'(g_idx[i]), 32'(i % 4));
            if (i > 0) check($sformatf("rr spacing %0d", i), 32'(g_cyc[i] - g_cyc[i-1]), 32'd2);
        end
        clear_inputs();
        tick();

        // Write 0x40, set 0x03, clear 0x01 through requester 2.
        set_lane(0, 2, 1'b1, 2'b00, 7'h40);
        tick();
        check("t3 write address", 32'(addr_a[0]), 32'd0);
        set_lane(0, 2, 1'b0, 2'b00, 7'h00);
        tick();
        set_lane(0, 2, 1'b1, 2'b01, 7'h03);
        tick();
        check("t3 set address", 32'(addr_a[0]), 32'd4);
        set_lane(0, 2, 1'b0, 2'b00, 7'h00);
        tick();
`ifdef PIO_SEQ_SHADOW_EN
        check("t3 shadow after set", 32'(sh_a[0]), 32'h43);
`endif
        set_lane(0, 2, 1'b1, 2'b10, 7'h01);
        tick();
        check("t3 clear address", 32'(addr_a[0]), 32'd5);
        check("t3 clear writedata", wd_a[0], 32'h01);
        set_lane(0, 2, 1'b0, 2'b00, 7'h00);
        tick();
`ifdef PIO_SEQ_SHADOW_EN
        check("t3 shadow after clear", 32'(sh_a[0]), 32'h42);
`endif

        // No-op: grant pulses without a bus cycle.
        set_lane(0, 1, 1'b1, 2'b11, 7'h7f);
        tick();
        check("nop grant", 32'(grant_a[0]), 32'b0010);
        check("nop chipselect", 32'(cs_a[0]), 32'd0);
        check("nop write_n", 32'(wn_a[0]), 32'd1);
        set_lane(0, 1, 1'b0, 2'b00, 7'h00);
        tick();
`ifdef PIO_SEQ_SHADOW_EN
        check("nop shadow", 32'(sh_a[0]), 32'h42);
`endif

        // GAP_CYCLES=3 instance with requesters 0 and 3 held.
        do_reset();
        g_idx.delete();
        g_cyc.delete();
        set_lane(1, 0, 1'b1, 2'b00, 7'h11);
        set_lane(1, 3, 1'b1, 2'b00, 7'h33);
        for (int t = 0; t < 12; t++) begin
            tick();
            if (cs_a[1]) begin
                g_cyc.push_back(cyc);
                g_idx.push_back(grant_a[1][3] ? 3 : 0);
            end
        end
        check("gap write count", 32'(g_cyc.size() >= 2), 32'd1);
        if (g_cyc.size() >= 2) begin
            check("gap spacing", 32'(g_cyc[1] - g_cyc[0]), 32'd5);
            check("gap first winner", 32'(g_idx[0]), 32'd0);
            check("gap second winner", 32'(g_idx[1]), 32'd3);
        end
        clear_inputs();
        repeat (6) tick();

        // Random traffic on both instances.
        for (int t = 0; t < 400; t++) begin
            random_stim(0);
            random_stim(1);
            tick();
        end
        clear_inputs();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) pend[k][i] = 1'b0;
        repeat (6) tick();

        // Reset asserted in the middle of an ISSUE cycle.
        set_lane(0, 2, 1'b1, 2'b00, 7'h2a);
        set_lane(1, 2, 1'b1, 2'b00, 7'h2a);
        tick();
        check("pre-reset chipselect", 32'(cs_a[0]), 32'd1);
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("async reset chipselect[%0d]", k), 32'(cs_a[k]), 32'd0);
            check($sformatf("async reset write_n[%0d]", k), 32'(wn_a[k]), 32'd1);
            check($sformatf("async reset grant[%0d]", k), 32'(grant_a[k]), 32'd0);
            check($sformatf("async reset busy[%0d]", k), 32'(busy_a[k]), 32'd0);
        end
        clear_inputs();
        for (int k = 0; k < 2; k++) begin
            set_lane(k, 3, 1'b1, 2'b00, 7'h03);
            set_lane(k, 0, 1'b1, 2'b00, 7'h0c);
        end
        @(posedge clk);
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        tick();
        check("post-reset winner dut0", 32'(grant_a[0]), 32'b0001);
        check("post-reset winner dut1", 32'(grant_a[1]), 32'b0001);
        clear_inputs();
        repeat (6) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
